// File: rtl/ascon_perm_sequencer_if.sv
// Request/response bundle between the mode FSM and the Ascon permutation sequencer.
// The mode FSM drives the request side and takes the result; the sequencer answers.
interface ascon_perm_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   num_rounds;
  logic [319:0] s_in;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] s_out;
  logic         busy;
  logic         err;

  modport master (
    output in_valid, num_rounds, s_in, out_ready,
    input  in_ready, out_valid, s_out, busy, err
  );

  modport slave (
    input  in_valid, num_rounds, s_in, out_ready,
    output in_ready, out_valid, s_out, busy, err
  );
endinterface

// File: rtl/ascon_perm_sequencer.sv
// Iterative Ascon permutation: applies 0..12 rounds (UNROLL rounds per clock) to a
// 320-bit state held in r_state, then presents the result until the consumer takes it.
module ascon_perm_sequencer #(
  parameter int UNROLL     = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ascon_perm_sequencer_if.slave bus
);

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_fsm;
  state_t         w_fsm_nxt;
  logic [319:0]   r_state;
  logic [319:0]   r_s_out;
  logic [3:0]     r_rem;
  logic [3:0]     r_idx;
  logic           r_out_valid;
  logic           r_err;

  logic           w_accept;
  logic [3:0]     w_eff;
  logic           w_over;
  logic [3:0]     w_step;
  logic           w_last;
  logic [319:0]   w_round1;
  logic [319:0]   w_round2;
  logic [319:0]   w_perm;

  function automatic logic [3:0] f_sat_rounds(input logic [3:0] n);
    return (n > MAX_R) ? MAX_R : n;
  endfunction

  function automatic logic [7:0] f_rc(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'hf0;
      4'd1:    return 8'he1;
      4'd2:    return 8'hd2;
      4'd3:    return 8'hc3;
      4'd4:    return 8'hb4;
      4'd5:    return 8'ha5;
      4'd6:    return 8'h96;
      4'd7:    return 8'h87;
      4'd8:    return 8'h78;
      4'd9:    return 8'h69;
      4'd10:   return 8'h5a;
      4'd11:   return 8'h4b;
      default: return 8'h00;
    endcase
  endfunction

  // One round: constant addition, bitsliced 5-bit S-box, per-lane linear diffusion.
  function automatic logic [319:0] f_round(input logic [319:0] s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128] ^ {56'd0, f_rc(idx)};
    x3 = s[127:64];
    x4 = s[63:0];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    return {x0, x1, x2, x3, x4};
  endfunction

  assign w_accept = bus.in_valid && (r_fsm == IDLE);
  assign w_eff    = f_sat_rounds(bus.num_rounds);
  assign w_over   = bus.num_rounds > MAX_R;
  assign w_round1 = f_round(r_state, r_idx);
  assign w_round2 = f_round(w_round1, r_idx + 4'd1);

  // With UNROLL=2 and one round left, the second round instance is bypassed.
  always_comb begin
    w_step = 4'd1;
    w_perm = w_round1;
    if (UNROLL == 2 && r_rem >= 4'd2) begin
      w_step = 4'd2;
      w_perm = w_round2;
    end
  end

  assign w_last = (r_rem <= w_step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (w_accept) w_fsm_nxt = (w_eff == 4'd0) ? DONE : RUN;
      RUN:     if (w_last) w_fsm_nxt = DONE;
      DONE:    if (bus.out_ready) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= '0;
      r_s_out     <= '0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_accept && w_over;
      case (r_fsm)
        IDLE: begin
          if (w_accept) begin
            r_state <= bus.s_in;
            r_rem   <= w_eff;
            r_idx   <= MAX_R - w_eff;
            if (w_eff == 4'd0) begin
              r_s_out     <= bus.s_in;
              r_out_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          r_state <= w_perm;
          r_rem   <= r_rem - w_step;
          r_idx   <= r_idx + w_step;
          if (w_last) begin
            r_s_out     <= w_perm;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_fsm == IDLE);
  assign bus.busy      = (r_fsm != IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.s_out     = r_s_out;
  assign bus.err       = r_err;

endmodule
